// File: rtl/cosine_lut_arb_pkg.sv
// Shared types and helpers for the cosine LUT arbiter: sizing, phase wrap, stage-1 record.
// Sample count and sample width default here unless the build defines them.
`ifndef CARRIER_SAMPLES_PER_PERIOD
`define CARRIER_SAMPLES_PER_PERIOD 12
`endif
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 16
`endif

package cosine_lut_arb_pkg;

  localparam int SAMPLES    = `CARRIER_SAMPLES_PER_PERIOD;
  localparam int LUT_ADDR_W = $clog2(SAMPLES);
  localparam int LUT_DATA_W = `FIXDT_64_A_WIDTH;
  localparam int ID_MAX_W   = 3;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Indices past the end of a non-power-of-two table fold back by one period.
  function automatic logic [LUT_ADDR_W-1:0] addr_wrap(input logic [LUT_ADDR_W-1:0] a);
    if (int'(a) >= SAMPLES) return a - LUT_ADDR_W'(SAMPLES);
    return a;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [ID_MAX_W-1:0]   id;
    logic [LUT_ADDR_W-1:0] addr;
  } s1_rec_t;

endpackage

// File: rtl/cosine_lut.sv
// Combinational cosine table, one period of 12 samples scaled to 32767 full-scale.
// READ_PORTS independent read ports share the same contents.
module cosine_lut
  import cosine_lut_arb_pkg::*;
#(
  parameter int READ_PORTS = 1,
  parameter int ADDR_W     = LUT_ADDR_W,
  parameter int DATA_W     = LUT_DATA_W
) (
  input  logic        [ADDR_W-1:0] addr [READ_PORTS],
  output logic signed [DATA_W-1:0] data [READ_PORTS]
);

  function automatic logic signed [DATA_W-1:0] cos_sample(input logic [ADDR_W-1:0] a);
    case (int'(a))
      0:       return DATA_W'(32767);
      1:       return DATA_W'(28377);
      2:       return DATA_W'(16384);
      3:       return DATA_W'(0);
      4:       return DATA_W'(-16384);
      5:       return DATA_W'(-28377);
      6:       return DATA_W'(-32767);
      7:       return DATA_W'(-28377);
      8:       return DATA_W'(-16384);
      9:       return DATA_W'(0);
      10:      return DATA_W'(16384);
      11:      return DATA_W'(28377);
      default: return '0;
    endcase
  endfunction

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    assign data[p] = cos_sample(addr[p]);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or above ptr wins, with wrap.
// Emits a one-hot grant and its index; all-zero grant when nothing requests.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    int  j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/cosine_lut_arbiter.sv
// Shares one cosine LUT read port among NUM_REQ requesters, one grant per cycle, 2-cycle latency;
// round-robin, or fixed priority (index 0 highest) with COSINE_LUT_ARB_STRICT_PRIO_EN. No response backpressure.
module cosine_lut_arbiter
  import cosine_lut_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = LUT_ADDR_W,
  parameter int DATA_W  = LUT_DATA_W,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ADDR_W-1:0]  req_addr [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [DATA_W-1:0]  rsp_data
);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    arb_ptr;
  logic               accept;
  s1_rec_t            s1;

  logic        [LUT_ADDR_W-1:0] lut_addr [1];
  logic signed [DATA_W-1:0]     lut_data [1];

  // No grants while held in reset, so nothing is accepted into a clearing pipeline.
  assign arb_req   = rst_n ? req_valid : '0;
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (arb_req),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef COSINE_LUT_ARB_STRICT_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  assign arb_ptr = rr_ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1.valid <= accept;
      if (accept) begin
        s1.id   <= ID_MAX_W'(grant_idx);
        s1.addr <= addr_wrap(req_addr[grant_idx]);
      end
    end
  end

  assign lut_addr[0] = s1.addr;

  cosine_lut #(
    .READ_PORTS (1),
    .ADDR_W     (LUT_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_lut (
    .addr (lut_addr),
    .data (lut_data)
  );

  // Data and id only move with a valid response so they hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1.valid ? (NUM_REQ'(1) << s1.id) : '0;
      if (s1.valid) begin
        rsp_id   <= s1.id[ID_W-1:0];
        rsp_data <= lut_data[0];
      end
    end
  end

endmodule

// File: tb/tb_cosine_lut_arbiter.sv
// Directed bench for cosine_lut_arbiter with a 12-sample, 16-bit table and two requesters.
module tb_cosine_lut_arbiter;

`ifdef COSINE_LUT_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [3:0]  req_addr [2];
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_data;

  int checks = 0;
  int failures = 0;
  int gold [12] = '{32767, 28377, 16384, 0, -16384, -28377,
                    -32767, -28377, -16384, 0, 16384, 28377};

  logic [1:0]  exp_v  [10];
  logic        exp_id [10];
  logic [15:0] exp_d  [10];
  logic [1:0]  g;
  int          k;

  cosine_lut_arbiter #(
    .NUM_REQ (2),
    .ADDR_W  (4),
    .DATA_W  (16),
    .ID_W    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] g16(input int idx);
    return 16'(gold[idx]);
  endfunction

  initial begin
    req_valid   = 2'b00;
    req_addr[0] = 4'd0;
    req_addr[1] = 4'd0;
    repeat (2) tick();

    // Reset state: outputs cleared, no grant even with requests pending.
    req_valid = 2'b11;
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from r0, addr 0.
    req_valid   = 2'b01;
    req_addr[0] = 4'd0;
    #1;
    check("single_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("single_ready_idle", req_ready, 2'b00);
    check("single_not_early", rsp_valid, 2'b00);
    tick();
    check("single_rsp_valid", rsp_valid, 2'b01);
    check("single_rsp_id", rsp_id, 1'b0);
    check("single_rsp_data", rsp_data, g16(0));
    tick();
    check("single_pulse_end", rsp_valid, 2'b00);
    check("single_data_hold", rsp_data, g16(0));

    // r1 with an out-of-range index 13 folds to LUT[1].
    req_valid   = 2'b10;
    req_addr[1] = 4'd13;
    #1;
    check("wrap1_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    check("wrap1_rsp_valid", rsp_valid, 2'b10);
    check("wrap1_rsp_id", rsp_id, 1'b1);
    check("wrap1_rsp_data", rsp_data, g16(1));
    tick();
    check("wrap1_pulse_end", rsp_valid, 2'b00);

    // Both requesters for 8 cycles; r1 always asks for the half-period sample.
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        req_valid   = 2'b11;
        req_addr[0] = 4'(k);
        req_addr[1] = 4'd6;
      end else begin
        req_valid = 2'b00;
      end
      g = (i >= 8) ? 2'b00 : ((STRICT || (i % 2 == 0)) ? 2'b01 : 2'b10);
      exp_v[i]  = g;
      exp_id[i] = g[1];
      exp_d[i]  = g[1] ? g16(6) : g16(k);
      #1;
      if (i < 8) check("alt_grant", req_ready, g);
      if (i >= 2) begin
        check("alt_rsp_valid", rsp_valid, exp_v[i-2]);
        if (exp_v[i-2] != 2'b00) begin
          check("alt_rsp_id", rsp_id, exp_id[i-2]);
          check("alt_rsp_data", rsp_data, exp_d[i-2]);
        end
      end
      if (g[0]) k++;
      tick();
    end
    check("alt_drained", rsp_valid, 2'b00);

    // Full-period sweep on r0, back-to-back.
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        req_valid   = 2'b01;
        req_addr[0] = 4'(i);
      end else begin
        req_valid = 2'b00;
      end
      #1;
      if (i >= 2) begin
        check("sweep_rsp_valid", rsp_valid, 2'b01);
        check("sweep_rsp_data", rsp_data, g16(i - 2));
      end
      tick();
    end
    check("sweep_end_valid", rsp_valid, 2'b00);
    check("sweep_end_hold", rsp_data, g16(11));

    // r0 index 15 folds to LUT[3].
    req_valid   = 2'b01;
    req_addr[0] = 4'd15;
    tick();
    req_valid = 2'b00;
    tick();
    check("wrap0_rsp_valid", rsp_valid, 2'b01);
    check("wrap0_rsp_data", rsp_data, g16(3));
    tick();

    // Reset one cycle after an acceptance drops the in-flight request.
    req_valid   = 2'b01;
    req_addr[0] = 4'd6;
    tick();
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    check("midrst_ready", req_ready, 2'b00);
    check("midrst_rsp_valid", rsp_valid, 2'b00);
    tick();
    check("midrst_rsp_valid2", rsp_valid, 2'b00);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    tick();
    check("postrst_rsp_valid", rsp_valid, 2'b00);
    tick();
    check("postrst_rsp_valid2", rsp_valid, 2'b00);

    // Contention after reset: grant starts at r0.
    for (int i = 0; i < 6; i++) begin
      req_valid   = 2'b11;
      req_addr[0] = 4'd2;
      req_addr[1] = 4'd4;
      #1;
      g = (STRICT || (i % 2 == 0)) ? 2'b01 : 2'b10;
      check("contend_grant", req_ready, g);
      tick();
    end
    req_valid = 2'b10;
    #1;
    check("r0_dropped_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cosine_lut_arbiter.md
Name: cosine_lut_arbiter

Overview:
- Shares one single-read-port cosine LUT (cosine_lut, READ_PORTS=1) between NUM_REQ requesters, e.g. the modulator carrier generator and the demodulator local-oscillator reference.
- Each requester presents a phase index through a valid/ready handshake and receives the LUT sample back a fixed 2 cycles after acceptance.
- Arbitration is round-robin by default; one grant per cycle, giving full throughput on the shared port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, $clog2(`CARRIER_SAMPLES_PER_PERIOD), phase-index width, matches the LUT input.
- DATA_W, `FIXDT_64_A_WIDTH, sample width, matches the LUT output.
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the response requester ID.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_addr  in  NUM_REQ x ADDR_W (unpacked)  per-requester phase index.
- req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and the arbiter pointer.
- rsp_valid  out  NUM_REQ  one-hot, single-cycle response strobe.
- rsp_id  out  ID_W  index of the requester owning rsp_data.
- rsp_data  out  DATA_W  registered LUT sample.

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr = 0, s1_valid = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - req_ready is 0 while rst_n is low.
- Grant:
  - req_ready = one-hot of the first asserted req_valid, searching from rr_ptr upward with wrap-around.
  - req_ready is all-zero when no req_valid is asserted.
  - Acceptance occurs on the edge where req_valid[i] & req_ready[i] are both high.
  - A requester holds valid and addr stable until accepted.
- Pointer: on an acceptance from requester g, rr_ptr <= (g+1) mod NUM_REQ. With no acceptance, rr_ptr holds.
- Pipeline, accept edge E:
  - Stage 1 at E: s1_addr, s1_id and s1_valid are registered.
  - The LUT is driven combinationally from s1_addr.
  - Stage 2 at E+1: rsp_data <= LUT out, rsp_id <= s1_id, rsp_valid <= onehot(s1_id) if s1_valid, else 0.
  - Latency is exactly 2 clocks from acceptance to rsp_valid high; rsp_valid is high for 1 cycle.
- Throughput and ordering:
  - One acceptance per cycle, back-to-back, no bubbles.
  - Responses return in acceptance order.
  - Responses have no backpressure; requesters must sink rsp_valid immediately.
- rsp_data and rsp_id hold their last value when rsp_valid = 0.
- Index range:
  - If req_addr >= `CARRIER_SAMPLES_PER_PERIOD (possible when the sample count is not a power of two), subtract `CARRIER_SAMPLES_PER_PERIOD once before stage 1 (phase wrap).
  - Indices below the sample count pass unchanged.
- Contention: all requesters valid every cycle means grants rotate 0,1,...,NUM_REQ-1,0,... with each requester served once per NUM_REQ cycles. No starvation.
- Reset mid-operation: in-flight stages are dropped (s1_valid and rsp_valid cleared immediately); no response is emitted for them after release.

Optional Feature:
- Macro: COSINE_LUT_ARB_STRICT_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed and the pointer logic is not built. Requester 0 is never blocked, and higher indices may starve.
- Undefined: round-robin as described above.

Decomposition:
- Shared package cosine_lut_arb_pkg: ID_W function/constant, the addr_wrap function (conditional subtract), and a typedef for the stage-1 record {valid, id, addr}.
- Sub-module rr_arbiter (NUM_REQ parameter; req, ptr in; one-hot grant and grant index out), reused elsewhere for sharing the modem's other tables.
- The cosine_lut instance lives inside this block.

Test Plan:
- Reset then a single request: req_valid=2'b01, addr=0 -> req_ready=2'b01 the same cycle; 2 clocks later rsp_valid=2'b01, rsp_id=0, rsp_data=LUT[0] (positive full-scale).
- Both requesters valid for 8 cycles: r0 addr=k, r1 addr=`CARRIER_SAMPLES_PER_PERIOD/2 -> grants alternate 01,10,01,... starting with r0; r1 always receives LUT[N/2] (negative full-scale); the response sequence mirrors the grant sequence delayed 2 cycles.
- Full sweep: r0 steps addr 0..N-1 every cycle, r1 idle -> N consecutive rsp_valid pulses with no gaps; rsp_data matches the golden round(cos(2*pi*k/N)*scale) table.
- Wrap (non-power-of-two N): addr=N+3 -> rsp_data=LUT[3].
- Reset asserted one cycle after an acceptance -> rsp_valid is never asserted for that request; after release rr_ptr=0 and the next grant goes to r0 when both are valid.
- With COSINE_LUT_ARB_STRICT_PRIO_EN and both valid for 6 cycles -> r0 is granted every cycle and r1 only once r0 drops.
